// File: rtl/lcd_bus_receiver.sv
// rtl/lcd_bus_receiver.sv - HD44780-style write-bus receiver with 2x16 buffer; busy model under LCDRX_BUSY_MODEL_EN
module lcd_bus_receiver #(
    parameter int BUSY_CMD = 4,
    parameter int BUSY_CLR = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [6:0] cursor_addr,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       busy,
    output logic       wr_strobe,
    output logic       err_busy
);

    logic       e_q;
    logic       rs_q;
    logic       rw_q;
    logic [7:0] d_q;
    logic [7:0] buffer [32];
    logic       incr_q;

    logic       fall;
    logic       take;
    logic       cmd_clear;
    logic       cmd_home;
    logic       cmd_entry;
    logic       cmd_disp;
    logic       cmd_shift;
    logic       cmd_ddram;
    logic       wr_ok;
    logic [4:0] wr_idx;

    // Falling edge of the enable strobe, using the bus values latched while E was high
    assign fall = e_q & ~lcd_e;

    // Command class by highest set bit of the latched byte
    assign cmd_clear = (d_q == 8'h01);
    assign cmd_home  = (d_q[7:1] == 7'h01);
    assign cmd_entry = (d_q[7:2] == 6'h01);
    assign cmd_disp  = (d_q[7:3] == 5'h01);
    assign cmd_shift = (d_q[7:4] == 4'h1);
    assign cmd_ddram = d_q[7];

    // Only 0x00-0x0F (line 1) and 0x40-0x4F (line 2) map onto the buffer
    assign wr_ok  = (cursor_addr[6:4] == 3'b000) || (cursor_addr[6:4] == 3'b100);
    assign wr_idx = {cursor_addr[6], cursor_addr[3:0]};

    assign rd_char = buffer[rd_addr];

`ifdef LCDRX_BUSY_MODEL_EN
    typedef enum logic [1:0] {IDLE, CLEAR, BUSY} state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] cnt_q;
    logic [4:0]  clr_idx_q;
    logic        err_d;

    assign take  = fall & ~rw_q & (state_q == IDLE);
    assign err_d = fall & ~rw_q & (state_q != IDLE);
    assign busy  = (state_q != IDLE);

    // Next-state: clear walks 32 entries, then the shared counter finishes the busy time
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = (!rs_q && cmd_clear) ? CLEAR : BUSY;
            CLEAR:   if (clr_idx_q == 5'd31) state_d = BUSY;
            BUSY:    if (cnt_q == 16'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Busy down-counter spans CLEAR and BUSY so total busy time equals the loaded value plus one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= 16'd0;
            clr_idx_q <= 5'd0;
            err_busy  <= 1'b0;
        end else begin
            err_busy <= err_d;
            if (take) begin
                cnt_q     <= (!rs_q && (cmd_clear || cmd_home)) ? 16'(BUSY_CLR - 1) : 16'(BUSY_CMD - 1);
                clr_idx_q <= 5'd0;
            end else begin
                if (state_q != IDLE && cnt_q != 16'd0) cnt_q <= cnt_q - 16'd1;
                if (state_q == CLEAR) clr_idx_q <= clr_idx_q + 5'd1;
            end
        end
    end
`else
    assign take     = fall & ~rw_q;
    assign busy     = 1'b0;
    assign err_busy = 1'b0;
`endif

    // Bus sampling registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q  <= 1'b0;
            rs_q <= 1'b0;
            rw_q <= 1'b0;
            d_q  <= 8'h00;
        end else begin
            e_q  <= lcd_e;
            rs_q <= lcd_rs;
            rw_q <= lcd_rw;
            d_q  <= lcd_data;
        end
    end

    // Character buffer: clear fill and data writes never coincide since writes need IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) buffer[i] <= 8'h20;
        end else begin
`ifdef LCDRX_BUSY_MODEL_EN
            if (state_q == CLEAR) buffer[clr_idx_q] <= 8'h20;
`else
            if (take && !rs_q && cmd_clear) begin
                for (int i = 0; i < 32; i++) buffer[i] <= 8'h20;
            end
`endif
            if (take && rs_q && wr_ok) buffer[wr_idx] <= d_q;
        end
    end

    // Cursor, entry mode, display flags and write strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cursor_addr <= 7'd0;
            incr_q      <= 1'b1;
            display_on  <= 1'b0;
            cursor_on   <= 1'b0;
            blink_on    <= 1'b0;
            wr_strobe   <= 1'b0;
        end else begin
            wr_strobe <= take & rs_q & wr_ok;
            if (take) begin
                if (rs_q) begin
                    cursor_addr <= incr_q ? cursor_addr + 7'd1 : cursor_addr - 7'd1;
                end else if (cmd_ddram) begin
                    cursor_addr <= d_q[6:0];
                end else if (cmd_shift) begin
                    if (!d_q[3]) cursor_addr <= d_q[2] ? cursor_addr + 7'd1 : cursor_addr - 7'd1;
                end else if (cmd_disp) begin
                    display_on <= d_q[2];
                    cursor_on  <= d_q[1];
                    blink_on   <= d_q[0];
                end else if (cmd_entry) begin
                    incr_q <= d_q[1];
                end else if (cmd_home) begin
                    cursor_addr <= 7'd0;
                end else if (cmd_clear) begin
                    cursor_addr <= 7'd0;
                    incr_q      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb/tb_lcd_bus_receiver.sv - scoreboard bench for lcd_bus_receiver
module tb_lcd_bus_receiver;

    localparam int BUSY_CMD = 4;
    localparam int BUSY_CLR = 40;
`ifdef LCDRX_BUSY_MODEL_EN
    localparam bit BM = 1'b1;
`else
    localparam bit BM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;
    logic [6:0] cursor_addr;
    logic       display_on;
    logic       cursor_on;
    logic       blink_on;
    logic       busy;
    logic       wr_strobe;
    logic       err_busy;

    lcd_bus_receiver #(.BUSY_CMD(BUSY_CMD), .BUSY_CLR(BUSY_CLR)) dut (
        .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_char(rd_char),
        .cursor_addr(cursor_addr), .display_on(display_on), .cursor_on(cursor_on),
        .blink_on(blink_on), .busy(busy), .wr_strobe(wr_strobe), .err_busy(err_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] mbuf [32];
    int         cur;
    bit         incr;
    bit         don, con, bon;
    int         busy_end;

    typedef struct { int cyc; bit err; } ev_t;
    ev_t expq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every wr_strobe / err_busy pulse must match the next expected event
    always @(negedge clk) begin
        while (expq.size() > 0 && expq[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_event: expected %s at cycle %0d, not observed", expq[0].err ? "err_busy" : "wr_strobe", expq[0].cyc);
            void'(expq.pop_front());
        end
        if (wr_strobe || err_busy) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: wr_strobe=%0b err_busy=%0b at cycle %0d, none expected", wr_strobe, err_busy, cyc);
            end else begin
                ev_t ev;
                ev = expq.pop_front();
                check("event_cycle", cyc, ev.cyc);
                check("event_err", err_busy, ev.err);
                check("event_strobe", wr_strobe, !ev.err);
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
        cur = 0; incr = 1'b1; don = 0; con = 0; bon = 0;
        busy_end = cyc;
    endtask

    // Transfer whose effects land at edge q
    task automatic apply(input bit rs, input bit rw, input logic [7:0] d, input int q);
        bit acc;
        acc = !rw && (q > busy_end);
        if (!rw && !acc) expq.push_back('{q, 1'b1});
        if (acc) begin
            if (rs) begin
                if (cur < 16) begin
                    mbuf[cur] = d; expq.push_back('{q, 1'b0});
                end else if (cur >= 64 && cur < 80) begin
                    mbuf[16 + cur - 64] = d; expq.push_back('{q, 1'b0});
                end
                cur = incr ? (cur + 1) % 128 : (cur + 127) % 128;
                if (BM) busy_end = q + BUSY_CMD;
            end else begin
                if (d == 1) begin
                    cur = 0; incr = 1'b1;
                    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
                end else if (d < 4) cur = 0;
                else if (d < 8) incr = d[1];
                else if (d < 16) begin don = d[2]; con = d[1]; bon = d[0]; end
                else if (d < 32) begin
                    if (!d[3]) cur = d[2] ? (cur + 1) % 128 : (cur + 127) % 128;
                end
                else if (d >= 128) cur = d - 128;
                if (BM) busy_end = q + ((d >= 1 && d < 4) ? BUSY_CLR : BUSY_CMD);
            end
        end
    endtask

    task automatic xfer(input bit rs, input bit rw, input logic [7:0] d);
        int q;
        @(posedge clk); #1;
        lcd_e = 1'b1; lcd_rs = rs; lcd_rw = rw; lcd_data = d;
        @(posedge clk); #1;
        lcd_e = 1'b0;
        q = cyc + 1;
        apply(rs, rw, d, q);
        @(posedge clk); #1;
        check("cursor_addr", cursor_addr, cur);
        check("flags", {display_on, cursor_on, blink_on}, {don, con, bon});
        check("busy", busy, cyc < busy_end);
    endtask

    task automatic wait_idle();
        while (cyc < busy_end) begin @(posedge clk); #1; end
        check("busy_idle", busy, 1'b0);
    endtask

    task automatic check_all();
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(i);
            #1;
            check($sformatf("rd_char[%0d]", i), rd_char, mbuf[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int r;
        rst = 1'b1; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h00; rd_addr = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check("rst_cursor", cursor_addr, 0);
        check("rst_flags", {display_on, cursor_on, blink_on}, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_strobe", wr_strobe, 1'b0);
        check("rst_err_busy", err_busy, 1'b0);
        check_all();
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        // Init sequence, each strobe after busy has dropped
        xfer(0, 0, 8'h38); wait_idle();
        xfer(0, 0, 8'h0C); wait_idle();
        xfer(0, 0, 8'h06); wait_idle();
        xfer(0, 0, 8'h01); wait_idle();
        check_all();
        xfer(1, 0, 8'h32); wait_idle();
        xfer(1, 0, 8'h33); wait_idle();
        xfer(0, 0, 8'hC0); wait_idle();
        xfer(1, 0, 8'h39); wait_idle();
        xfer(0, 0, 8'h8F); wait_idle();
        xfer(1, 0, 8'h41); wait_idle();
        xfer(1, 0, 8'h42); wait_idle();
        xfer(0, 0, 8'h04); wait_idle();
        xfer(0, 0, 8'h80); wait_idle();
        xfer(1, 0, 8'h55); wait_idle();
        check_all();

        // Data strobed shortly after a clear
        xfer(0, 0, 8'h01);
        xfer(1, 0, 8'h31);
        wait_idle();
        check_all();

        // Reset in the middle of a clear
        xfer(0, 0, 8'h0F); wait_idle();
        xfer(0, 0, 8'h01);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("busy_async_rst", busy, 1'b0);
        @(posedge clk); #1;
        check("busy_after_rst", busy, 1'b0);
        model_reset();
        check("rst_flags_mid", {display_on, cursor_on, blink_on}, 3'b000);
        rst = 1'b0;
        check_all();

        // Randomized traffic
        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 9);
            d = 8'($urandom);
            if (r < 4) xfer(1, 0, d);
            else if (r < 6) xfer(0, 0, {1'b1, 1'($urandom_range(0, 1)), 2'b00, 4'($urandom)});
            else if (r == 6 && cyc >= busy_end) xfer(1'($urandom), 1, d);
            else if (r == 7 && $urandom_range(0, 5) == 0) xfer(0, 0, 8'h01);
            else xfer(0, 0, 8'($urandom_range(2, 63)));
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
            if (k % 25 == 24) begin
                wait_idle();
                check_all();
            end
        end

        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("pending_events", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_bus_receiver.md
Name: lcd_bus_receiver

Overview:
- Display-side end of the character-LCD write bus (lcd_e, lcd_rs, lcd_rw, lcd_data) that the calculator drives.
- Decodes HD44780-style commands and data writes, maintains a 2x16 character buffer, cursor address and display-control flags, and models the controller busy time.
- Used as a synthesizable display model in benches and as a bus checker on hardware debug builds.

Parameters:
- BUSY_CMD, 4: busy cycles after an accepted command or data write other than clear/home.
- BUSY_CLR, 40: busy cycles after clear (0x01) or home (0x02/0x03). Must be >= 33.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- lcd_e  in  1  enable strobe; a transfer is taken on its falling edge.
- lcd_rs  in  1  0 = command, 1 = data.
- lcd_rw  in  1  0 = write, 1 = read.
- lcd_data  in  8  command or character byte.
- rd_addr  in  5  buffer read index; 0-15 is line 1, 16-31 is line 2.
- rd_char  out  8  buffer[rd_addr], combinational read.
- cursor_addr  out  7  current DDRAM address.
- display_on, cursor_on, blink_on  out  1 each  display-control flags.
- busy  out  1  controller busy.
- wr_strobe  out  1  one-cycle pulse when a character lands in the buffer.
- err_busy  out  1  one-cycle pulse when a transfer arrives while busy.

Behaviour:
- Reset (async, rst=1):
  - All 32 buffer bytes = 0x20.
  - cursor_addr = 0, entry increment = 1.
  - display_on = cursor_on = blink_on = 0.
  - busy = wr_strobe = err_busy = 0; FSM = IDLE.
  - Reset during CLEAR or BUSY aborts that operation immediately.
- Sampling:
  - lcd_e, lcd_rs, lcd_rw and lcd_data are registered every cycle (e_q, rs_q, rw_q, d_q).
  - A falling edge is e_q=1 and lcd_e=0 in cycle N. The transfer uses rs_q, rw_q and d_q from that cycle.
  - All effects are visible in cycle N+1.
- Read transfers (rw_q=1) are ignored: no state change, no busy.
- FSM states: IDLE, CLEAR, BUSY.
  - IDLE, transfer taken: decode it, load busy counter, go to BUSY, or to CLEAR for 0x01.
  - IDLE or CLEAR or BUSY, falling edge while busy: transfer dropped, err_busy pulses at N+1.
  - CLEAR: writes 0x20 to one buffer entry per cycle, index 0..31, 32 cycles. Then BUSY for the remainder of BUSY_CLR.
  - BUSY: down-counter reaches 0, go to IDLE.
  - busy = 1 in CLEAR and BUSY.
- Command decode (rs_q=0), by highest set bit of d_q:
  - 0x01: cursor_addr = 0, entry increment = 1, buffer cleared via CLEAR.
  - 0x02/0x03: cursor_addr = 0; buffer unchanged; BUSY_CLR.
  - 0x04-0x07: entry increment = d_q[1]. d_q[0] (shift) is ignored.
  - 0x08-0x0F: display_on = d_q[2], cursor_on = d_q[1], blink_on = d_q[0].
  - 0x10-0x1F:
    - d_q[3]=0: cursor_addr moves +1 if d_q[2]=1, else -1.
    - d_q[3]=1 (display shift): ignored.
  - 0x20-0x3F (function set), 0x40-0x7F (CGRAM address): accepted, no state change, BUSY_CMD.
  - 0x80-0xFF: cursor_addr = d_q[6:0].
- Data decode (rs_q=1):
  - cursor_addr 0x00-0x0F writes buffer[addr].
  - cursor_addr 0x40-0x4F writes buffer[16 + addr[3:0]].
  - Either valid write pulses wr_strobe at N+1.
  - Any other address: the write is dropped and wr_strobe stays 0.
  - cursor_addr then moves +1 or -1 per entry increment, with 7-bit wrap: 0x7F+1 = 0x00, 0x00-1 = 0x7F.
- A cursor move, clear or home never alters display flags. Only 0x01 alters entry increment.

Optional Feature:
- Macro name: LCDRX_BUSY_MODEL_EN.
- Defined:
  - Busy timing, the CLEAR fill sequence and err_busy are as above.
- Undefined:
  - busy and err_busy are tied 0 and every transfer is accepted.
  - 0x01 clears all 32 entries in cycle N+1 in parallel.
  - The FSM stays in IDLE.

Test Plan:
- Reset, then sequence 0x38, 0x0C, 0x06, 0x01, with each strobe issued only after busy=0 -> display_on=1, cursor_on=0, blink_on=0, cursor_addr=0, all rd_char=0x20, no err_busy.
- Data '2'(0x32), '3'(0x33) -> rd_char[0]=0x32, rd_char[1]=0x33, cursor_addr=2, two wr_strobe pulses.
- Command 0xC0, then data '9'(0x39) -> rd_char[16]=0x39, cursor_addr=0x41.
- Command 0x8F, data 0x41, data 0x42 -> buffer[15]=0x41. 0x42 is dropped at address 0x10 (no wr_strobe). cursor_addr=0x11.
- Command 0x04 (decrement), 0x80, then data 0x55 -> buffer[0]=0x55, cursor_addr=0x7F.
- Strobe data 0x31 two cycles after 0x01 -> err_busy pulses, buffer stays all 0x20. Assert rst mid-CLEAR -> busy=0 on the next edge.
